avalon_st_mult_stream: RTL and testbench

AVALON_ST_MULT_STREAM -- requirements
Module: avalon_st_mult_stream

---
 rtl/avalon_st_mult_stream.sv | 175 +++++++++++++++++
 tb/tb_avalon_st_mult_stream.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_st_mult_stream.sv
// Avalon-ST unsigned multiplier: collects A then B (MSB byte first) from one packet and
// streams the full-width product back as a 2*NB-beat packet, MSB byte first.
module avalon_st_mult_stream #(
  parameter int unsigned SZ    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  input  logic             startofpacket_in,
  input  logic             endofpacket_in,
  output logic             ready_out,
  output logic [7:0]       data_out,
  output logic             valid_out,
  output logic             startofpacket_out,
  output logic             endofpacket_out,
  input  logic             ready_in,
  output logic             error_out,
  output logic [CNT_W-1:0] pkt_count_out
);

  localparam int unsigned NB    = SZ / 8;
  localparam int unsigned NBEAT = 2 * NB;
  localparam int unsigned IW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NBEAT - 1);

  typedef enum logic [1:0] {StRx, StCalc, StTx} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW-1:0]       tx_idx_q, tx_idx_d;
  logic [SZ-1:0]       a_q, a_d, b_q, b_d;
  logic [2*SZ-1:0]     p_q, p_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;
  logic [7:0]          data_q, data_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept;
  logic [IW-1:0]       tx_nxt;

  // Byte k of the product in transmit order (k = 0 is the most significant byte).
  function automatic logic [7:0] p_byte(input logic [2*SZ-1:0] p, input logic [IW-1:0] k);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < int'(NBEAT); i++) begin
      if (k == IW'(NBEAT - 1 - i)) r = p[8*i +: 8];
    end
    return r;
  endfunction

  assign accept = ready_q & valid_in;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tx_idx_d = tx_idx_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    valid_d  = valid_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    tx_nxt   = tx_idx_q + IW'(1);
    case (state_q)
      StRx: begin
        if (accept) begin
          if (startofpacket_in) begin
            // SOP+EOP cannot be a complete packet, so it is malformed.
            if (endofpacket_in) begin
              err_d = 1'b1;
              idx_d = '0;
            end else begin
              a_d[SZ-8 +: 8] = data_in;
              idx_d          = IW'(1);
            end
          end else if (idx_q == '0) begin
            err_d = 1'b1;
          end else if (endofpacket_in != (idx_q == LastIdx)) begin
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            for (int i = 0; i < int'(NB); i++) begin
              if (idx_q == IW'(NB - 1 - i))    a_d[8*i +: 8] = data_in;
              if (idx_q == IW'(NBEAT - 1 - i)) b_d[8*i +: 8] = data_in;
            end
            if (idx_q == LastIdx) begin
              state_d = StCalc;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
      end
      StCalc: begin
        p_d      = {{SZ{1'b0}}, a_q} * {{SZ{1'b0}}, b_q};
        tx_idx_d = '0;
        state_d  = StTx;
      end
      StTx: begin
        if (!valid_q) begin
          valid_d  = 1'b1;
          sop_d    = 1'b1;
          eop_d    = 1'b0;
          data_d   = p_byte(p_q, '0);
          tx_idx_d = '0;
        end else if (ready_in) begin
          if (tx_idx_q == LastIdx) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            data_d  = '0;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = StRx;
          end else begin
            tx_idx_d = tx_nxt;
            sop_d    = 1'b0;
            eop_d    = (tx_nxt == LastIdx);
            data_d   = p_byte(p_q, tx_nxt);
          end
        end
      end
      default: state_d = StRx;
    endcase
    ready_d = (state_d == StRx);
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q  <= StRx;
      idx_q    <= '0;
      tx_idx_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tx_idx_q <= tx_idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      data_q   <= data_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready_out         = ready_q;
  assign data_out          = data_q;
  assign valid_out         = valid_q;
  assign startofpacket_out = sop_q;
  assign endofpacket_out   = eop_q;
  assign error_out         = err_q;
  assign pkt_count_out     = cnt_q;

endmodule

// File: tb/tb_avalon_st_mult_stream.sv
// Bench for avalon_st_mult_stream: SZ=32 directed/table packets and an SZ=16 random run,
// with per-instance scoreboards popped by output monitors.
module tb_avalon_st_mult_stream;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  // SZ=32 instance
  logic [7:0]  d32, dout32;
  logic        v32, s32, e32, rdy32, vout32, sout32, eout32, rin32, err32;
  logic [15:0] cnt32;
  // SZ=16 instance
  logic [7:0]  d16, dout16;
  logic        v16, s16, e16, rdy16, vout16, sout16, eout16, rin16, err16;
  logic [15:0] cnt16;

  int   checks = 0;
  int   errors = 0;
  exp_t q32[$];
  exp_t q16[$];
  int   err_seen32 = 0;
  int   exp_err32  = 0;
  int   exp_cnt32  = 0;
  bit   rnd_rdy16  = 1'b0;

  always #5 clk = ~clk;

  avalon_st_mult_stream #(.SZ(32), .CNT_W(16)) dut32 (
    .clk_in(clk), .rst(rst), .data_in(d32), .valid_in(v32), .startofpacket_in(s32),
    .endofpacket_in(e32), .ready_out(rdy32), .data_out(dout32), .valid_out(vout32),
    .startofpacket_out(sout32), .endofpacket_out(eout32), .ready_in(rin32),
    .error_out(err32), .pkt_count_out(cnt32)
  );

  avalon_st_mult_stream #(.SZ(16), .CNT_W(16)) dut16 (
    .clk_in(clk), .rst(rst), .data_in(d16), .valid_in(v16), .startofpacket_in(s16),
    .endofpacket_in(e16), .ready_out(rdy16), .data_out(dout16), .valid_out(vout16),
    .startofpacket_out(sout16), .endofpacket_out(eout16), .ready_in(rin16),
    .error_out(err16), .pkt_count_out(cnt16)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors sample mid-cycle; inputs change only 1 time unit after a rising edge.
  logic       stall32 = 1'b0, stall16 = 1'b0;
  logic [10:0] prev32, prev16;

  always @(negedge clk) begin
    if (!rst) begin
      stall32 = 1'b0;
    end else begin
      if (stall32) chk("stall_hold32", {53'd0, vout32, sout32, eout32, dout32}, {53'd0, prev32});
      if (vout32 && rin32) begin
        if (q32.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat32: got unexpected beat %0h, expected none", dout32);
        end else begin
          exp_t e;
          e = q32.pop_front();
          chk("beat32", {54'd0, sout32, eout32, dout32}, {54'd0, e.sop, e.eop, e.d});
        end
      end
      stall32 = vout32 && !rin32;
      prev32  = {vout32, sout32, eout32, dout32};
      if (err32) err_seen32++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      stall16 = 1'b0;
    end else begin
      if (stall16) chk("stall_hold16", {53'd0, vout16, sout16, eout16, dout16}, {53'd0, prev16});
      if (vout16 && rin16) begin
        if (q16.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat16: got unexpected beat %0h, expected none", dout16);
        end else begin
          exp_t e;
          e = q16.pop_front();
          chk("beat16", {54'd0, sout16, eout16, dout16}, {54'd0, e.sop, e.eop, e.d});
        end
      end
      stall16 = vout16 && !rin16;
      prev16  = {vout16, sout16, eout16, dout16};
      if (err16) chk("no_error16", 64'(err16), 64'd0);
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy16) begin
      #1;
      rin16 = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_beat(input bit inst, input logic [7:0] d, input logic s, input logic e);
    int n = 0;
    while (!(inst ? rdy16 : rdy32) && n < 200) begin
      tick();
      n++;
    end
    chk("sink_ready", 64'(inst ? rdy16 : rdy32), 64'd1);
    if (inst) begin
      d16 = d; s16 = s; e16 = e; v16 = 1'b1;
    end else begin
      d32 = d; s32 = s; e32 = e; v32 = 1'b1;
    end
    tick();
    if (inst) v16 = 1'b0;
    else v32 = 1'b0;
  endtask

  task automatic send_pkt(input bit inst, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] p);
    int nb = inst ? 2 : 4;
    for (int k = 0; k < 2 * nb; k++) begin
      exp_t e;
      e.d   = p[8*(2*nb-1-k) +: 8];
      e.sop = (k == 0);
      e.eop = (k == 2 * nb - 1);
      if (inst) q16.push_back(e);
      else q32.push_back(e);
    end
    for (int k = 0; k < nb; k++) send_beat(inst, a[8*(nb-1-k) +: 8], k == 0, 1'b0);
    for (int k = 0; k < nb; k++) send_beat(inst, b[8*(nb-1-k) +: 8], 1'b0, k == nb - 1);
  endtask

  task automatic drain(input bit inst);
    int n = 0;
    while (((inst ? q16.size() : q32.size()) != 0 || (inst ? vout16 : vout32)) && n < 4000) begin
      tick();
      n++;
    end
    chk("drain_queue_empty", 64'(inst ? q16.size() : q32.size()), 64'd0);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{a: 32'h0000_FFFF, b: 32'h0001_0001, p: 64'h0000_0000_FFFF_FFFF};
    tbl[1] = '{a: 32'h0001_0000, b: 32'h0001_0000, p: 64'h0000_0001_0000_0000};
    tbl[2] = '{a: 32'h8000_0000, b: 32'h0000_0002, p: 64'h0000_0001_0000_0000};
    tbl[3] = '{a: 32'h0000_0000, b: 32'hDEAD_BEEF, p: 64'h0};
    tbl[4] = '{a: 32'h0100_0000, b: 32'h0100_0000, p: 64'h0001_0000_0000_0000};
    tbl[5] = '{a: 32'h0000_00FF, b: 32'h0000_0100, p: 64'h0000_0000_0000_FF00};

    rst = 1'b0;
    {d32, v32, s32, e32} = '0;
    {d16, v16, s16, e16} = '0;
    rin32 = 1'b1;
    rin16 = 1'b1;
    #3;
    chk("reset_outputs32", {40'd0, rdy32, vout32, sout32, eout32, err32, dout32, cnt32}, 64'd0);
    repeat (2) tick();
    chk("reset_ready_held32", 64'(rdy32), 64'd0);
    rst = 1'b1;
    chk("ready_before_edge", 64'(rdy32), 64'd0);
    tick();
    chk("ready_after_release32", 64'(rdy32), 64'd1);
    chk("ready_after_release16", 64'(rdy16), 64'd1);

    // 3*5 with latency check: valid_out two edges after the last sink beat.
    send_pkt(1'b0, 32'd3, 32'd5, 64'h0F);
    chk("lat_edge0_valid", 64'(vout32), 64'd0);
    chk("lat_ready_low", 64'(rdy32), 64'd0);
    tick();
    chk("lat_edge1_valid", 64'(vout32), 64'd0);
    tick();
    chk("lat_edge2_valid_sop", {62'd0, vout32, sout32}, 64'd3);
    drain(1'b0);
    exp_cnt32++;
    chk("count_after_first", 64'(cnt32), 64'(exp_cnt32));

    for (int i = 0; i < 6; i++) begin
      send_pkt(1'b0, tbl[i].a, tbl[i].b, tbl[i].p);
      drain(1'b0);
      exp_cnt32++;
      chk("count_table", 64'(cnt32), 64'(exp_cnt32));
    end

    // Downstream stall while product byte 2 is presented.
    send_pkt(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    for (int n = 0; q32.size() > 6 && n < 100; n++) tick();
    chk("stall_beat2_presented", {55'd0, vout32, dout32}, {55'd0, 1'b1, 8'hFF});
    rin32 = 1'b0;
    repeat (3) tick();
    chk("stall_beat2_still", {55'd0, vout32, dout32}, {55'd0, 1'b1, 8'hFF});
    rin32 = 1'b1;
    drain(1'b0);
    exp_cnt32++;
    chk("count_stall", 64'(cnt32), 64'(exp_cnt32));

    // EOP on beat 4.
    for (int k = 0; k < 4; k++) send_beat(1'b0, 8'(k + 1), k == 0, 1'b0);
    send_beat(1'b0, 8'h55, 1'b0, 1'b1);
    exp_err32++;
    chk("early_eop_err", {62'd0, err32, rdy32}, 64'd3);
    tick();
    chk("early_eop_err_clear", {62'd0, err32, rdy32}, 64'd1);
    chk("early_eop_no_output", 64'(vout32), 64'd0);
    send_pkt(1'b0, 32'h11, 32'h11, 64'h121);
    drain(1'b0);
    exp_cnt32++;
    chk("count_after_eop_err", 64'(cnt32), 64'(exp_cnt32));

    // Beat without SOP while idle, SOP+EOP beat, and missing EOP on the last beat.
    send_beat(1'b0, 8'hAA, 1'b0, 1'b0);
    exp_err32++;
    chk("no_sop_err", 64'(err32), 64'd1);
    send_beat(1'b0, 8'hAA, 1'b1, 1'b1);
    exp_err32++;
    chk("sop_eop_err", 64'(err32), 64'd1);
    for (int k = 0; k < 8; k++) send_beat(1'b0, 8'h01, k == 0, 1'b0);
    exp_err32++;
    chk("missing_eop_err", 64'(err32), 64'd1);
    tick();
    chk("missing_eop_no_output", 64'(vout32), 64'd0);

    // Restart by SOP at beat 5 then a full 2*7 packet.
    for (int k = 0; k < 5; k++) send_beat(1'b0, 8'hC3, k == 0, 1'b0);
    send_pkt(1'b0, 32'd2, 32'd7, 64'h0E);
    drain(1'b0);
    exp_cnt32++;
    chk("count_after_restart", 64'(cnt32), 64'(exp_cnt32));
    tick();
    chk("error_pulse_total", 64'(err_seen32), 64'(exp_err32));

    // Reset during output beat 3.
    send_pkt(1'b0, 32'h1234_5678, 32'h0000_0100, 64'h0000_0012_3456_7800);
    for (int n = 0; q32.size() > 5 && n < 100; n++) tick();
    chk("rst_mid_tx_valid", 64'(vout32), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_outputs", {40'd0, rdy32, vout32, sout32, eout32, err32, dout32, cnt32}, 64'd0);
    q32.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_release_ready_low", 64'(rdy32), 64'd0);
    tick();
    chk("rst_release_ready", {47'd0, rdy32, cnt32}, {47'd0, 1'b1, 16'd0});
    send_pkt(1'b0, 32'd9, 32'd9, 64'd81);
    drain(1'b0);
    chk("count_after_reset", 64'(cnt32), 64'd1);

    // SZ=16: fixed vector, then back-to-back random packets with random stalls.
    send_pkt(1'b1, 32'hABCD, 32'h1234, 64'h0C37_4FA4);
    drain(1'b1);
    chk("count16_first", 64'(cnt16), 64'd1);
    rnd_rdy16 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a, b;
      logic [31:0] p;
      a = 16'($urandom);
      b = 16'($urandom);
      if (i == 0) begin
        a = 16'hFFFF;
        b = 16'hFFFF;
      end
      p = {16'd0, a} * {16'd0, b};
      send_pkt(1'b1, {16'd0, a}, {16'd0, b}, {32'd0, p});
    end
    drain(1'b1);
    rnd_rdy16 = 1'b0;
    tick();
    rin16 = 1'b1;
    chk("count16_random", 64'(cnt16), 64'd301);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
